// File: rtl/vending_discount_scheduler_if.sv
// ----------------------------------------------------------------------------
// vending_discount_scheduler_if: request/result bundle for the discount adder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface vending_discount_scheduler_if #(
  parameter int DATA_WIDTH = 64,
  parameter int K          = 16
);
  localparam int W = DATA_WIDTH * K;

  logic         ab_valid;
  logic         ab_ready;
  logic [W-1:0] discountA;
  logic [W-1:0] discountB;
  logic         cd_valid;
  logic         cd_ready;
  logic [W-1:0] discountC;
  logic [W-1:0] discountD;
  logic         sum_valid;
  logic         sum_ready;
  logic [W-1:0] total_discount;
  logic         sel;
  logic         busy;
  logic [15:0]  done_count;

  modport slave (
    input  ab_valid, discountA, discountB,
    output ab_ready,
    input  cd_valid, discountC, discountD,
    output cd_ready,
    output sum_valid,
    input  sum_ready,
    output total_discount, sel, busy, done_count
  );

  modport master (
    output ab_valid, discountA, discountB,
    input  ab_ready,
    output cd_valid, discountC, discountD,
    input  cd_ready,
    input  sum_valid,
    output sum_ready,
    input  total_discount, sel, busy, done_count
  );
endinterface

`default_nettype wire

// File: rtl/vending_discount_scheduler.sv
// ----------------------------------------------------------------------------
// vending_discount_scheduler: two-channel round-robin chunk-serial adder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vending_discount_scheduler #(
  parameter int DATA_WIDTH = 64,
  parameter int K          = 16
) (
  input  wire logic                      clk,
  input  wire logic                      reset,
  vending_discount_scheduler_if.slave    bus
);

  localparam int W    = DATA_WIDTH * K;
  localparam int IDXW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(K - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            prio_ab_q, prio_ab_d;
  logic            sel_q, sel_d;
  logic            carry_q, carry_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    opx_q, opx_d;
  logic [W-1:0]    opy_q, opy_d;
  logic [W-1:0]    partial_q, partial_d;
  logic [W-1:0]    total_q, total_d;
  logic [15:0]     done_count_q, done_count_d;

  logic            w_ab_grant;
  logic            w_cd_grant;
  logic            w_ab_ready;
  logic            w_cd_ready;
  logic [DATA_WIDTH:0] w_sum;
  logic [W-1:0]    w_chunk_ext;

  assign w_ab_grant = bus.ab_valid && (!bus.cd_valid || prio_ab_q);
  assign w_cd_grant = bus.cd_valid && (!bus.ab_valid || !prio_ab_q);

  // Operands shift right each ADD cycle, so the active chunk is always bits [DATA_WIDTH-1:0].
  assign w_sum = {1'b0, opx_q[DATA_WIDTH-1:0]}
               + {1'b0, opy_q[DATA_WIDTH-1:0]}
               + {{DATA_WIDTH{1'b0}}, carry_q};
  assign w_chunk_ext = W'(w_sum[DATA_WIDTH-1:0]);

  always_comb begin
    state_d      = state_q;
    prio_ab_d    = prio_ab_q;
    sel_d        = sel_q;
    carry_d      = carry_q;
    idx_d        = idx_q;
    opx_d        = opx_q;
    opy_d        = opy_q;
    partial_d    = partial_q;
    total_d      = total_q;
    done_count_d = done_count_q;
    w_ab_ready   = 1'b0;
    w_cd_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        w_ab_ready = w_ab_grant;
        w_cd_ready = w_cd_grant;
        if (w_ab_grant) begin
          opx_d   = bus.discountA;
          opy_d   = bus.discountB;
          sel_d   = 1'b1;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = ADD;
        end else if (w_cd_grant) begin
          opx_d   = bus.discountC;
          opy_d   = bus.discountD;
          sel_d   = 1'b0;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = ADD;
        end
      end

      ADD: begin
        opx_d     = opx_q >> DATA_WIDTH;
        opy_d     = opy_q >> DATA_WIDTH;
        carry_d   = w_sum[DATA_WIDTH];
        // New chunk enters at the top; after K cycles chunk 0 has reached the bottom.
        partial_d = (partial_q >> DATA_WIDTH) | (w_chunk_ext << (W - DATA_WIDTH));
        idx_d     = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          total_d = partial_d;
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.sum_ready) begin
          done_count_d = done_count_q + 16'd1;
          prio_ab_d    = ~sel_q;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      prio_ab_q    <= 1'b1;
      sel_q        <= 1'b1;
      carry_q      <= 1'b0;
      idx_q        <= '0;
      opx_q        <= '0;
      opy_q        <= '0;
      partial_q    <= '0;
      total_q      <= '0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      prio_ab_q    <= prio_ab_d;
      sel_q        <= sel_d;
      carry_q      <= carry_d;
      idx_q        <= idx_d;
      opx_q        <= opx_d;
      opy_q        <= opy_d;
      partial_q    <= partial_d;
      total_q      <= total_d;
      done_count_q <= done_count_d;
    end
  end

  assign bus.ab_ready       = w_ab_ready;
  assign bus.cd_ready       = w_cd_ready;
  assign bus.sum_valid      = (state_q == DONE);
  assign bus.total_discount = total_q;
  assign bus.sel            = sel_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.done_count     = done_count_q;

endmodule

`default_nettype wire

// File: tb/tb_vending_discount_scheduler.sv
// ----------------------------------------------------------------------------
// tb_vending_discount_scheduler: vector table plus scoreboard of expected sums
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vending_discount_scheduler;

  localparam int DW = 64;
  localparam int KK = 16;
  localparam int W  = DW * KK;

  typedef struct {
    bit           is_ab;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] exp;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    bit           sel;
  } exp_t;

  logic  clk;
  logic  reset;
  logic  mon_en;
  int    n_pass;
  int    n_total;
  logic [15:0] exp_done;
  exp_t  sbq[$];
  exp_t  e_mon;
  vec_t  tv[5];

  vending_discount_scheduler_if #(.DATA_WIDTH(DW), .K(KK)) bus ();

  vending_discount_scheduler #(.DATA_WIDTH(DW), .K(KK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got hi=%h lo=%h want hi=%h lo=%h",
                  name, act[W-1:W-64], act[63:0], exp[W-1:W-64], exp[63:0]);
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Result monitor: every sum handshake is scored against the head of the queue.
  always @(negedge clk) begin
    if (reset) begin
      exp_done = 16'd0;
    end else if (mon_en && bus.sum_valid && bus.sum_ready) begin
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_result: got sum_valid=1 total lo=%h want no pending result",
                 bus.total_discount[63:0]);
      end else begin
        e_mon = sbq.pop_front();
        check("sum", bus.total_discount, e_mon.sum);
        check("sel", W'(bus.sel), W'(e_mon.sel));
      end
      check("done_count_at_handshake", W'(bus.done_count), W'(exp_done));
      exp_done = exp_done + 16'd1;
    end
  end

  task automatic req(input bit ab, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] exp, input bit push);
    int n;
    n = 0;
    if (ab) begin
      bus.ab_valid = 1'b1; bus.discountA = x; bus.discountB = y;
    end else begin
      bus.cd_valid = 1'b1; bus.discountC = x; bus.discountD = y;
    end
    #1;
    while (!(ab ? bus.ab_ready : bus.cd_ready) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 200) begin
      n_total++;
      $display("FAIL accept_timeout: got ready=0 for %0d cycles want ready=1", n);
    end else if (push) begin
      sbq.push_back('{exp, ab});
    end
    @(posedge clk); #1;
    // Scramble operands after accept; the sum in progress must not see this.
    if (ab) begin
      bus.ab_valid = 1'b0; bus.discountA = rand_w(); bus.discountB = rand_w();
    end else begin
      bus.cd_valid = 1'b0; bus.discountC = rand_w(); bus.discountD = rand_w();
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (sbq.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d pending results want 0", sbq.size());
      sbq.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int acc;
    logic [W-1:0] t;

    n_pass = 0; n_total = 0; mon_en = 1'b0; exp_done = 16'd0;
    reset = 1'b1;
    bus.ab_valid = 1'b0; bus.cd_valid = 1'b0; bus.sum_ready = 1'b0;
    bus.discountA = '0; bus.discountB = '0; bus.discountC = '0; bus.discountD = '0;

    // Vector table
    tv[0] = '{1'b0, W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), W'(1) << 64};
    tv[1] = '{1'b1, {W{1'b1}}, W'(1), '0};
    t = {1'b0, {(W-1){1'b1}}};
    tv[2] = '{1'b0, t, W'(1), W'(1) << (W - 1)};
    tv[3].is_ab = 1'b1; tv[3].x = rand_w(); tv[3].y = rand_w(); tv[3].exp = tv[3].x + tv[3].y;
    tv[4].is_ab = 1'b0; tv[4].x = rand_w(); tv[4].y = rand_w(); tv[4].exp = tv[4].x + tv[4].y;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;

    check("rst_ab_ready", W'(bus.ab_ready), '0);
    check("rst_cd_ready", W'(bus.cd_ready), '0);
    check("rst_sum_valid", W'(bus.sum_valid), '0);
    check("rst_total", bus.total_discount, '0);
    check("rst_sel", W'(bus.sel), W'(1));
    check("rst_busy", W'(bus.busy), '0);
    check("rst_done_count", W'(bus.done_count), '0);

    // Single AB request with latency measurement
    bus.sum_ready = 1'b1;
    req(1'b1, W'(1), W'(2), W'(3), 1'b1);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!bus.sum_valid && n < 40);
    check("latency_cycles", W'(n), W'(17));
    wait_drain();
    check("done_count_after_first", W'(bus.done_count), W'(1));

    for (int i = 0; i < 5; i++) begin
      req(tv[i].is_ab, tv[i].x, tv[i].y, tv[i].exp, 1'b1);
      wait_drain();
    end

    // Both channels valid continuously from reset: strict alternation
    reset = 1'b1;
    @(posedge clk); #1;
    bus.ab_valid = 1'b1; bus.discountA = W'(5); bus.discountB = W'(6);
    bus.cd_valid = 1'b1; bus.discountC = W'(7); bus.discountD = W'(8);
    sbq.push_back('{W'(11), 1'b1});
    sbq.push_back('{W'(15), 1'b0});
    sbq.push_back('{W'(11), 1'b1});
    sbq.push_back('{W'(15), 1'b0});
    reset = 1'b0;
    acc = 0; n = 0;
    while (acc < 4 && n < 200) begin
      @(negedge clk); #1; n++;
      if (bus.ab_ready || bus.cd_ready) begin
        acc++;
        check("ready_only_in_idle", W'(bus.busy), '0);
        check("ready_exclusive", W'(bus.ab_ready && bus.cd_ready), '0);
        check("grant_order_ab", W'(bus.ab_ready), W'(acc % 2 == 1));
      end
    end
    if (acc < 4) begin
      n_total++;
      $display("FAIL rr_accept_timeout: got %0d accepts want 4", acc);
    end
    @(posedge clk); #1;
    bus.ab_valid = 1'b0; bus.cd_valid = 1'b0;
    wait_drain();

    // Backpressure with CD waiting
    bus.sum_ready = 1'b0;
    req(1'b1, W'(1), W'(2), W'(3), 1'b1);
    bus.cd_valid = 1'b1; bus.discountC = W'(7); bus.discountD = W'(8);
    n = 0;
    while (!bus.sum_valid && n < 40) begin
      @(negedge clk); #1; n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_sum_valid", W'(bus.sum_valid), W'(1));
      check("bp_total", bus.total_discount, W'(3));
      check("bp_cd_ready", W'(bus.cd_ready), '0);
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    bus.sum_ready = 1'b1;
    sbq.push_back('{W'(15), 1'b0});
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("bp_cd_accept_next_idle", W'(bus.cd_ready), W'(1));
    check("bp_idle_after_handshake", W'(bus.busy), '0);
    @(posedge clk); #1;
    bus.cd_valid = 1'b0;
    wait_drain();

    // Reset during chunk 8 of 16 drops the request
    req(1'b1, rand_w(), rand_w(), '0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_sum_valid", W'(bus.sum_valid), '0);
    check("midrst_total", bus.total_discount, '0);
    check("midrst_busy", W'(bus.busy), '0);
    check("midrst_done_count", W'(bus.done_count), '0);
    check("midrst_sel", W'(bus.sel), W'(1));
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_late_result", W'(bus.sum_valid), '0);
    req(1'b1, W'(9), W'(10), W'(19), 1'b1);
    wait_drain();
    check("done_count_after_reset", W'(bus.done_count), W'(1));

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
